// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: SOAK/WASH/RINSE/SPIN with pause/resume and cancel-to-DRAIN.
// Optional macro POWER_RESTART_PHASE_EN: a resume after a power-loss pause restarts the saved phase at full length.
module wash_cycle_sequencer #(
  parameter int CNT_W       = 16,
  parameter int SOAK_TICKS  = 8,
  parameter int WASH_TICKS  = 16,
  parameter int RINSE_TICKS = 12,
  parameter int SPIN_TICKS  = 10,
  parameter int DRAIN_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             lid,
  input  logic             power_on,
  input  logic             mode1,
  input  logic             mode2,
  input  logic             mode3,
  input  logic             mode4,
  output logic [2:0]       state,
  output logic [1:0]       phase_sel,
  output logic             soak_en,
  output logic             wash_en,
  output logic             rinse_en,
  output logic             spin_en,
  output logic             timer_enable,
  output logic [CNT_W-1:0] counter_out,
  output logic             lid_lock,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAUSE = 3'd1,
    S_SOAK  = 3'd2,
    S_WASH  = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DRAIN = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    P_SOAK  = 2'b00,
    P_WASH  = 2'b01,
    P_RINSE = 2'b10,
    P_SPIN  = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    M_QUICK  = 2'd0,
    M_NORMAL = 2'd1,
    M_HEAVY  = 2'd2,
    M_SPIN   = 2'd3
  } mode_t;

  state_t           cur_state, nxt_state;
  phase_t           saved_phase, nxt_saved_phase;
  mode_t            mode_r, nxt_mode;
  mode_t            sel_mode;
  phase_t           first_phase, cur_phase, next_phase;
  logic [1:0]       cur_phase_bits;
  logic [CNT_W-1:0] nxt_counter;
  logic             pause_req;
  logic             heavy;
  logic [1:0]       nxt_phase_sel;

`ifdef POWER_RESTART_PHASE_EN
  logic             power_lost, nxt_power_lost;
`endif

  // Heavy programs double every phase except SPIN; result is the counter load value.
  function automatic logic [CNT_W-1:0] full_count(input phase_t p, input logic dbl);
    int t;
    case (p)
      P_SOAK:  t = SOAK_TICKS;
      P_WASH:  t = WASH_TICKS;
      P_RINSE: t = RINSE_TICKS;
      default: t = SPIN_TICKS;
    endcase
    if (dbl && (p != P_SPIN)) t = 2 * t;
    return CNT_W'(t - 1);
  endfunction

  function automatic state_t phase_state(input phase_t p);
    return state_t'({1'b0, p} + 3'd2);
  endfunction

  function automatic logic [1:0] phase_of(input state_t s);
    logic [2:0] d;
    d = s - 3'd2;
    return d[1:0];
  endfunction

  function automatic logic is_phase(input state_t s);
    return (s == S_SOAK) || (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
  endfunction

  assign state = cur_state;

  // Same-edge priority is reset > cancel > pause > phase completion.
  always_comb begin
    nxt_state       = cur_state;
    nxt_counter     = counter_out;
    nxt_saved_phase = saved_phase;
    nxt_mode        = mode_r;
    pause_req       = lid || !power_on;
    heavy           = (mode_r == M_HEAVY);
    cur_phase_bits  = phase_of(cur_state);
    cur_phase       = phase_t'(cur_phase_bits);
    next_phase      = phase_t'(cur_phase_bits + 2'd1);

    if (mode1)      sel_mode = M_QUICK;
    else if (mode2) sel_mode = M_NORMAL;
    else if (mode3) sel_mode = M_HEAVY;
    else            sel_mode = M_SPIN;

    case (sel_mode)
      M_QUICK:           first_phase = P_WASH;
      M_NORMAL, M_HEAVY: first_phase = P_SOAK;
      default:           first_phase = P_SPIN;
    endcase

`ifdef POWER_RESTART_PHASE_EN
    nxt_power_lost = power_lost;
`endif

    case (cur_state)
      S_IDLE: begin
        if (start && !lid && power_on && (mode1 || mode2 || mode3 || mode4)) begin
          nxt_mode        = sel_mode;
          nxt_saved_phase = first_phase;
          nxt_state       = phase_state(first_phase);
          nxt_counter     = full_count(first_phase, sel_mode == M_HEAVY);
`ifdef POWER_RESTART_PHASE_EN
          nxt_power_lost  = 1'b0;
`endif
        end
      end

      S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
        if (cancel) begin
          nxt_state   = S_DRAIN;
          nxt_counter = CNT_W'(DRAIN_TICKS - 1);
        end else if (pause_req) begin
          nxt_state       = S_PAUSE;
          nxt_saved_phase = cur_phase;
`ifdef POWER_RESTART_PHASE_EN
          nxt_power_lost  = !power_on;
`endif
        end else if (counter_out == '0) begin
          if (cur_phase == P_SPIN) begin
            nxt_state   = S_DONE;
            nxt_counter = '0;
          end else begin
            nxt_state       = phase_state(next_phase);
            nxt_saved_phase = next_phase;
            nxt_counter     = full_count(next_phase, heavy);
          end
        end else begin
          nxt_counter = counter_out - 1'b1;
        end
      end

      S_PAUSE: begin
        if (cancel) begin
          nxt_state   = S_DRAIN;
          nxt_counter = CNT_W'(DRAIN_TICKS - 1);
        end else if (!pause_req) begin
          nxt_state = phase_state(saved_phase);
`ifdef POWER_RESTART_PHASE_EN
          if (power_lost) nxt_counter = full_count(saved_phase, heavy);
          nxt_power_lost = 1'b0;
`endif
`ifdef POWER_RESTART_PHASE_EN
        end else if (!power_on) begin
          nxt_power_lost = 1'b1;
`endif
        end
      end

      // Drain ignores the lid but freezes while mains is absent.
      S_DRAIN: begin
        if (power_on) begin
          if (counter_out == '0) nxt_state = S_IDLE;
          else                   nxt_counter = counter_out - 1'b1;
        end
      end

      S_DONE: begin
        nxt_state   = S_IDLE;
        nxt_counter = '0;
      end

      default: begin
        nxt_state   = S_IDLE;
        nxt_counter = '0;
      end
    endcase

    nxt_phase_sel = 2'b00;
    if (nxt_state == S_PAUSE)      nxt_phase_sel = nxt_saved_phase;
    else if (is_phase(nxt_state))  nxt_phase_sel = phase_of(nxt_state);
  end

  // All panel and driver outputs are decoded from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state    <= S_IDLE;
      saved_phase  <= P_SOAK;
      mode_r       <= M_QUICK;
      counter_out  <= '0;
      phase_sel    <= 2'b00;
      soak_en      <= 1'b0;
      wash_en      <= 1'b0;
      rinse_en     <= 1'b0;
      spin_en      <= 1'b0;
      timer_enable <= 1'b0;
      lid_lock     <= 1'b0;
      done         <= 1'b0;
`ifdef POWER_RESTART_PHASE_EN
      power_lost   <= 1'b0;
`endif
    end else begin
      cur_state    <= nxt_state;
      saved_phase  <= nxt_saved_phase;
      mode_r       <= nxt_mode;
      counter_out  <= nxt_counter;
      phase_sel    <= nxt_phase_sel;
      soak_en      <= (nxt_state == S_SOAK);
      wash_en      <= (nxt_state == S_WASH);
      rinse_en     <= (nxt_state == S_RINSE);
      spin_en      <= (nxt_state == S_SPIN);
      timer_enable <= is_phase(nxt_state) || ((nxt_state == S_DRAIN) && power_on);
      lid_lock     <= (nxt_state == S_SPIN);
      done         <= (nxt_state == S_DONE);
`ifdef POWER_RESTART_PHASE_EN
      power_lost   <= nxt_power_lost;
`endif
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench for wash_cycle_sequencer: a program-queue reference model predicts every cycle's outputs.
// Build with POWER_RESTART_PHASE_EN defined to exercise the full-length restart after power loss.
module tb_wash_cycle_sequencer;
  localparam int CNT_W    = 16;
  localparam int SOAK_T   = 8;
  localparam int WASH_T   = 16;
  localparam int RINSE_T  = 12;
  localparam int SPIN_T   = 10;
  localparam int DRAIN_T  = 4;
  localparam int ST_IDLE  = 0;
  localparam int ST_PAUSE = 1;
  localparam int ST_SPIN  = 5;
  localparam int ST_DRAIN = 6;
  localparam int ST_DONE  = 7;
`ifdef POWER_RESTART_PHASE_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, cancel, lid, power_on, mode1, mode2, mode3, mode4;
  logic [2:0] state;
  logic [1:0] phase_sel;
  logic soak_en, wash_en, rinse_en, spin_en, timer_enable, lid_lock, done;
  logic [CNT_W-1:0] counter_out;

  wash_cycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .lid(lid), .power_on(power_on),
    .mode1(mode1), .mode2(mode2), .mode3(mode3), .mode4(mode4),
    .state(state), .phase_sel(phase_sel), .soak_en(soak_en), .wash_en(wash_en),
    .rinse_en(rinse_en), .spin_en(spin_en), .timer_enable(timer_enable),
    .counter_out(counter_out), .lid_lock(lid_lock), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int psel; int cnt;
    bit soak; bit wash; bit rinse; bit spin; bit timer; bit lock; bit dn;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0, pushed = 0, popped = 0;

  // Reference model: a program is a list of (phase, length) pairs consumed one at a time.
  int m_state = 0, m_phase = 0, m_cnt = 0, m_full = 0;
  bit m_lost = 1'b0;
  int prog_phase[$];
  int prog_len[$];

  task automatic check_output(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== 32'(expected)) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic load_program();
    prog_phase.delete();
    prog_len.delete();
    if (mode1) begin
      prog_phase = '{1, 2, 3};          prog_len = '{WASH_T, RINSE_T, SPIN_T};
    end else if (mode2) begin
      prog_phase = '{0, 1, 2, 3};       prog_len = '{SOAK_T, WASH_T, RINSE_T, SPIN_T};
    end else if (mode3) begin
      prog_phase = '{0, 1, 2, 3};       prog_len = '{2*SOAK_T, 2*WASH_T, 2*RINSE_T, SPIN_T};
    end else begin
      prog_phase = '{3};                prog_len = '{SPIN_T};
    end
  endtask

  task automatic enter_next_phase();
    m_phase = prog_phase.pop_front();
    m_full  = prog_len.pop_front();
    m_cnt   = m_full - 1;
    m_state = 2 + m_phase;
  endtask

  task automatic model_step();
    bit pause_req;
    pause_req = lid || !power_on;
    if (!rst_n) begin
      m_state = ST_IDLE; m_cnt = 0; m_phase = 0; m_lost = 1'b0;
      prog_phase.delete(); prog_len.delete();
    end else if (m_state == ST_IDLE) begin
      if (start && !lid && power_on && (mode1 || mode2 || mode3 || mode4)) begin
        load_program();
        enter_next_phase();
        m_lost = 1'b0;
      end
    end else if (m_state == ST_DONE) begin
      m_state = ST_IDLE;
    end else if (m_state == ST_DRAIN) begin
      if (power_on) begin
        if (m_cnt == 0) m_state = ST_IDLE;
        else            m_cnt--;
      end
    end else if (cancel) begin
      m_state = ST_DRAIN; m_cnt = DRAIN_T - 1; m_lost = 1'b0;
      prog_phase.delete(); prog_len.delete();
    end else if (m_state == ST_PAUSE) begin
      if (!pause_req) begin
        m_state = 2 + m_phase;
        if (RESTART_EN && m_lost) m_cnt = m_full - 1;
        m_lost = 1'b0;
      end else if (!power_on) begin
        m_lost = 1'b1;
      end
    end else if (pause_req) begin
      m_state = ST_PAUSE;
      m_lost  = !power_on;
    end else if (m_cnt == 0) begin
      if (prog_phase.size() == 0) begin
        m_state = ST_DONE; m_cnt = 0;
      end else begin
        enter_next_phase();
      end
    end else begin
      m_cnt--;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    bit in_phase;
    in_phase = (m_state >= 2) && (m_state <= 5);
    e.st    = m_state;
    e.cnt   = m_cnt;
    e.psel  = (in_phase || m_state == ST_PAUSE) ? m_phase : 0;
    e.soak  = (m_state == 2);
    e.wash  = (m_state == 3);
    e.rinse = (m_state == 4);
    e.spin  = (m_state == 5);
    e.timer = in_phase || ((m_state == ST_DRAIN) && power_on);
    e.lock  = (m_state == ST_SPIN);
    e.dn    = (m_state == ST_DONE);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outputs());
    pushed++;
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_stimulus(input logic [3:0] m);
    {mode4, mode3, mode2, mode1} = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_model(input int st, input int cnt, input int bound);
    int n;
    n = 0;
    while (!(m_state == st && (cnt < 0 || m_cnt == cnt)) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) check_output("wait_bound", 1, 0);
  endtask

  task automatic measure_done(input logic [3:0] m, input int expected, input string name);
    int n;
    apply_stimulus(m);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check_output(name, n, expected);
  endtask

  // Monitor: every negedge the DUT presents one cycle of outputs to compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        check_output("state", state, e.st);
        check_output("phase_sel", phase_sel, e.psel);
        check_output("counter_out", counter_out, e.cnt);
        check_output("soak_en", soak_en, e.soak);
        check_output("wash_en", wash_en, e.wash);
        check_output("rinse_en", rinse_en, e.rinse);
        check_output("spin_en", spin_en, e.spin);
        check_output("timer_enable", timer_enable, e.timer);
        check_output("lid_lock", lid_lock, e.lock);
        check_output("done", done, e.dn);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; lid = 1'b0; power_on = 1'b1;
    {mode4, mode3, mode2, mode1} = 4'b0000;
    run_cycles(3);
    rst_n = 1'b1;
    check_output("reset_state", state, ST_IDLE);
    check_output("reset_counter", counter_out, 0);

    measure_done(4'b0001, WASH_T + RINSE_T + SPIN_T, "quick_done_latency");
    run_cycles(2);
    measure_done(4'b1100, 2*SOAK_T + 2*WASH_T + 2*RINSE_T + SPIN_T, "heavy_done_latency");
    run_cycles(2);

    apply_stimulus(4'b0010);
    wait_model(3, 9, 100);
    power_on = 1'b0;
    run_cycles(30);
    check_output("power_pause_state", state, ST_PAUSE);
    check_output("power_pause_count", counter_out, 9);
    check_output("power_pause_timer", timer_enable, 0);
    power_on = 1'b1;
    tick();
    check_output("power_resume_state", state, 3);
    check_output("power_resume_count", counter_out, RESTART_EN ? WASH_T - 1 : 9);
    wait_model(ST_IDLE, -1, 400);

    apply_stimulus(4'b1000);
    run_cycles(3);
    lid = 1'b1;
    tick();
    check_output("spin_pause_state", state, ST_PAUSE);
    check_output("spin_pause_lock", lid_lock, 0);
    check_output("spin_pause_en", spin_en, 0);
    run_cycles(3);
    lid = 1'b0;
    tick();
    check_output("spin_resume_state", state, ST_SPIN);
    wait_model(ST_IDLE, -1, 100);

    lid = 1'b1;
    {mode4, mode3, mode2, mode1} = 4'b0001;
    start = 1'b1;
    run_cycles(3);
    check_output("start_lid_open", state, ST_IDLE);
    start = 1'b0;
    lid = 1'b0;
    tick();

    apply_stimulus(4'b0001);
    run_cycles(5);
    lid = 1'b1;
    run_cycles(2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    lid = 1'b0;
    check_output("cancel_pause_state", state, ST_DRAIN);
    check_output("cancel_pause_count", counter_out, DRAIN_T - 1);
    run_cycles(DRAIN_T);
    check_output("drain_end_state", state, ST_IDLE);

    apply_stimulus(4'b0010);
    run_cycles(3);
    cancel = 1'b1;
    lid = 1'b1;
    tick();
    cancel = 1'b0;
    check_output("cancel_lid_state", state, ST_DRAIN);
    run_cycles(DRAIN_T);
    check_output("drain_lid_end", state, ST_IDLE);
    lid = 1'b0;

    apply_stimulus(4'b0001);
    wait_model(4, -1, 100);
    run_cycles(3);
    rst_n = 1'b0;
    tick();
    check_output("midrun_reset_state", state, ST_IDLE);
    check_output("midrun_reset_count", counter_out, 0);
    check_output("midrun_reset_rinse", rinse_en, 0);
    rst_n = 1'b1;

    apply_stimulus(4'b0010);
    {mode4, mode3, mode2, mode1} = 4'b0001;
    start = 1'b1;
    run_cycles(20);
    start = 1'b0;
    wait_model(ST_IDLE, -1, 400);

    for (int i = 0; i < 2500; i++) begin
      start    = ($urandom_range(0, 99) < 15);
      {mode4, mode3, mode2, mode1} = 4'($urandom_range(0, 15));
      lid      = ($urandom_range(0, 99) < 4);
      power_on = ($urandom_range(0, 99) >= 4);
      cancel   = ($urandom_range(0, 199) < 2);
      rst_n    = ($urandom_range(0, 999) >= 3);
      tick();
    end

    start = 1'b0; cancel = 1'b0; lid = 1'b0; power_on = 1'b1; rst_n = 1'b1;
    tick();
    @(negedge clk);
    #1;
    check_output("scoreboard_empty", exp_q.size(), 0);
    check_output("scoreboard_pops", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
